// File: rtl/mem_ctrl.sv
// mem_ctrl: two-port round-robin controller that serializes block reads/writes onto one mem port.
// One transaction in flight: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
`ifndef BLK_WIDTH
`define BLK_WIDTH 128
`endif
`ifndef PA_WIDTH
`define PA_WIDTH 20
`endif

module mem_ctrl #(
    parameter int BLK_WIDTH = `BLK_WIDTH,
    parameter int PA_WIDTH  = `PA_WIDTH,
    parameter int MEM_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [PA_WIDTH-1:0]  addr0,
    input  logic [PA_WIDTH-1:0]  addr1,
    input  logic [BLK_WIDTH-1:0] wdata0,
    input  logic [BLK_WIDTH-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [BLK_WIDTH-1:0] rdata,
    output logic                 busy,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_data,
    input  logic [BLK_WIDTH-1:0] mem_rd_data
);
    localparam int OFF_BITS = $clog2(BLK_WIDTH / 8);
    localparam logic [PA_WIDTH-1:0] OFF_MASK = PA_WIDTH'((1 << OFF_BITS) - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_ptr;
    logic                 r_id;
    logic                 r_we;
    logic [3:0]           r_cnt;
    logic [PA_WIDTH-1:0]  r_addr;
    logic [BLK_WIDTH-1:0] r_wdata;
    logic [BLK_WIDTH-1:0] r_rdata;

    logic                 w_grant;
    logic [PA_WIDTH-1:0]  w_addr_blk;

    // Lone requester wins outright; on a tie the priority pointer decides.
    always_comb begin
        w_grant = r_ptr;
        if (req0 && !req1) begin
            w_grant = 1'b0;
        end else if (req1 && !req0) begin
            w_grant = 1'b1;
        end
        w_addr_blk = (w_grant ? addr1 : addr0) & ~OFF_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_id    <= w_grant;
                        r_we    <= w_grant ? we1 : we0;
                        r_addr  <= w_addr_blk;
                        r_wdata <= w_grant ? wdata1 : wdata0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 4'(MEM_LAT);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Last wait cycle: mem's registered read data is stable by now.
                    if (r_cnt == 4'd1) begin
                        if (!r_we) begin
                            r_rdata <= mem_rd_data;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ptr   <= ~r_id;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack0        = (r_state == S_RESP) && !r_id;
    assign ack1        = (r_state == S_RESP) && r_id;
    assign busy        = (r_state != S_IDLE);
    assign mem_rd_en   = (r_state == S_ISSUE) && !r_we;
    assign mem_wr_en   = (r_state == S_ISSUE) && r_we;
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wdata;
    assign rdata       = r_rdata;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Two-port, round-robin memory controller that sequences block transfers into the main-memory array (`mem`). It accepts block-read and block-write requests from two requesters (port 0: instruction-cache refill, port 1: data-cache refill/writeback), serializes them onto the single `mem` port, and models extra DRAM latency. One transaction is in flight at a time.

## Interface

**Parameters**
- `BLK_WIDTH`, default `` `BLK_WIDTH ``: block size in bits, a multiple of 8.
- `PA_WIDTH`, default `` `PA_WIDTH ``: physical address width in bits.
- `MEM_LAT`, default 2: wait cycles between issue and response. Legal range is 1..15.
- Derived: `OFF_BITS` = log2(`BLK_WIDTH`/8), the block-offset bits.

**Ports**
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req0`, `req1` in 1: request from port 0 / port 1.
- `we0`, `we1` in 1: 1 = block write, 0 = block read.
- `addr0`, `addr1` in `PA_WIDTH`: byte address. Offset bits are ignored.
- `wdata0`, `wdata1` in `BLK_WIDTH`: write block.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata` out `BLK_WIDTH`: read block, shared by both ports. It is valid only with the ack of a read.
- `busy` out 1: a transaction is in progress (state ≠ IDLE).
- `mem_addr` out `PA_WIDTH`: block address to `mem`, with offset bits forced to 0.
- `mem_rd_en`, `mem_wr_en` out 1: enables to `mem`. At most one is high, for exactly one cycle per transaction.
- `mem_wr_data` out `BLK_WIDTH`: write block to `mem`.
- `mem_rd_data` in `BLK_WIDTH`: block from `mem`. It is registered inside `mem` and valid from the cycle after `mem_rd_en`.

## Operation

**FSM:** IDLE → ISSUE → WAIT → RESP → IDLE.

- **IDLE**
  - Arbitrate among the asserted `req` lines.
  - Latch the winner's id, `we`, `addr` (offset bits zeroed) and `wdata`.
  - Go to ISSUE. With no request, stay in IDLE.
- **ISSUE**
  - Drive `mem_addr`/`mem_wr_data` from the latched registers.
  - Assert `mem_rd_en` (read) or `mem_wr_en` (write) for this one cycle.
  - Load the wait counter with `MEM_LAT`. Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When it reaches 1, capture `mem_rd_data` into the `rdata` register (reads only) and go to RESP.
- **RESP**
  - Assert `ackN` for the latched port only.
  - Update the round-robin pointer. Go to IDLE.

**Arbitration**
- Use a 1-bit priority pointer, reset to port 0.
- If only one request is asserted, it wins.
- If both are asserted, the pointer's port wins. After the grant, the pointer moves to the other port.
- Result: two ports continuously requesting strictly alternate.

**Requester protocol**
- Hold `req`/`we`/`addr`/`wdata` stable until `ack`. The inputs are sampled only in IDLE.
- A `req` still high in the cycle after `ack` is treated as a new request.
- Deasserting `req` before `ack` does not cancel the transaction; the ack still pulses.

**Data handling**
- `mem_addr` and `mem_wr_data` hold their last latched values outside ISSUE.
- `rdata` holds until the next read capture. Writes leave `rdata` unchanged.

**Reset**
- Takes effect at the next rising edge with `rst`=1, from any state. It forces IDLE and clears the pointer and counter.
- A transaction in flight is abandoned and no ack is issued.
- If `mem_wr_en` was already asserted, that write to `mem` completes and is not undone.

## Timing

- **Reset values:** `ack0`=`ack1`=0, `mem_rd_en`=`mem_wr_en`=0, `busy`=0, `mem_addr`=0, `mem_wr_data`=0, `rdata`=0.
- **Latency:** if `req` is sampled in IDLE in cycle t, then:
  - ISSUE is in cycle t+1;
  - WAIT covers cycles t+2..t+MEM_LAT+1;
  - `ack` is in cycle t+MEM_LAT+2.
- **Throughput:** back-to-back transactions are MEM_LAT+3 cycles apart, because IDLE takes one cycle between RESP and the next ISSUE.
- **No combinational paths:** `ack*`, `busy`, `mem_*_en` decode from the state register only, and all datapath outputs are registered. Nothing passes combinationally from `req*` to any output.
- **Simultaneous events:** a new request arriving during RESP is not seen until the following IDLE cycle. Both requests asserted in the same IDLE cycle are resolved by the pointer.

## Test plan

Configuration: `BLK_WIDTH`=128, `PA_WIDTH`=20, `MEM_LAT`=2.

1. **Write then read:**
   - Release reset.
   - Port 0 write, addr 0x00040, wdata 128'h0123…CDEF. Expect `mem_wr_en` high at t+1 with `mem_addr`=0x00040, and `ack0` at t+4.
   - Then a port 0 read of 0x00040. Expect `ack0` at t'+4 with `rdata`=128'h0123…CDEF.
2. **Simultaneous requests after reset:**
   - `req0`=`req1`=1 at cycle 0. Expect port 0 served first (`ack0` at cycle 4) and port 1 next (sampled cycle 5, `ack1` at cycle 9).
3. **Fairness:**
   - Both requests held high for 6 transactions. Expect the acks to strictly alternate 0,1,0,1,0,1, spaced 5 cycles apart.
4. **Unaligned address:**
   - Port 1 read, addr 0x00047. Expect `mem_addr`=0x00040 and `rdata` equal to the block at 0x00040.
5. **Reset during WAIT:**
   - Assert `rst` for one cycle during WAIT of a port 1 read. Expect no `ack1`, and next cycle `busy`=0 with both `mem` enables 0.
   - A following port 0 request completes normally and is granted first, since the pointer was reset.
6. **Read-only `rdata`:**
   - Read A (value X), then write B. Expect `rdata` still X after the write's ack.
